mask_index_encoder: RTL

//   Sequential encoder: accepts a WIDTH-bit bitmask and emits the index of every
//   set bit, one per beat, highest-priority (MSB) first. Inverse of the one-hot

---
 rtl/mask_index_encoder_if.sv | 43 ++++
 rtl/mask_index_encoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mask_index_encoder_if.sv
// Handshake bundle for mask_index_encoder.
// The upstream side presents a mask on in_*. The downstream side takes one
// beat per set bit on out_*. The producer/consumer drives the master modport,
// and the encoder sits on the slave modport.
interface mask_index_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_mask;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               out_zero;
    logic [IDX_W:0]     out_seq;

    modport master (
        output in_valid,
        output in_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  out_zero,
        input  out_seq
    );

    modport slave (
        input  in_valid,
        input  in_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output out_zero,
        output out_seq
    );
endinterface

// File: rtl/mask_index_encoder.sv
// mask_index_encoder
// Takes a WIDTH-bit mask and streams the index of each set bit, one beat per
// handshake, MSB first. Index i refers to mask bit WIDTH-1-i. An all-zero mask
// produces a single dummy beat with out_zero set. This lets the bit-serial PE
// scheduler skip zero bits.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a mask; in_ready high, out_valid low
//   EMIT  | presenting beats from rem_q until the last one is taken
//
// rem_q holds the bits that have not been handed off yet, including the bit
// currently on out_idx. Every out_* field is registered. When a beat is
// accepted, the next beat is computed from the updated remainder. Beat 0 is
// computed straight from in_mask, so the first beat appears on the cycle
// after the accept.
module mask_index_encoder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mask_index_encoder_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               out_zero_q, out_zero_d;
    logic [IDX_W:0]     out_seq_q, out_seq_d;

    logic               accept;
    logic               beat_done;
    logic [WIDTH-1:0]   clr_bit;
    logic [WIDTH-1:0]   rem_next;

    // Index of the most significant set bit, counted from the MSB.
    // An all-zero mask returns 0, which is also the dummy-beat index.
    function automatic logic [IDX_W-1:0] first_idx(input logic [WIDTH-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (m[b]) begin
                r = IDX_W'(WIDTH - 1 - b);
            end
        end
        return r;
    endfunction

    // True when zero or one bit is set. A nonzero mask with one bit left is
    // on its last beat. A zero mask is its own last beat.
    function automatic logic at_most_one(input logic [WIDTH-1:0] m);
        return (m & (m - WIDTH'(1))) == '0;
    endfunction

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_seq   = out_seq_q;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign beat_done = out_valid_q && bus.out_ready;

    // Clear the mask bit named by the beat currently on the output.
    always_comb begin
        clr_bit = '0;
        clr_bit[IDX_W'(WIDTH - 1) - out_idx_q] = 1'b1;
        rem_next = rem_q & ~clr_bit;
    end

    // Next-state and next-beat logic. All outputs hold unless a mask is
    // accepted or a beat is handed off.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_zero_d  = out_zero_q;
        out_seq_d   = out_seq_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = EMIT;
                    rem_d       = bus.in_mask;
                    out_valid_d = 1'b1;
                    out_idx_d   = first_idx(bus.in_mask);
                    out_last_d  = at_most_one(bus.in_mask);
                    out_zero_d  = (bus.in_mask == '0);
                    out_seq_d   = '0;
                end
            end
            EMIT: begin
                if (beat_done) begin
                    rem_d = rem_next;
                    if (out_last_q) begin
                        // Keep the last beat's fields visible; only valid drops.
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        out_idx_d  = first_idx(rem_next);
                        out_last_d = at_most_one(rem_next);
                        out_zero_d = 1'b0;
                        out_seq_d  = out_seq_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears everything, including any
    // beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_seq_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_zero_q  <= out_zero_d;
            out_seq_q   <= out_seq_d;
        end
    end
endmodule
